// File: rtl/mem_responder.sv
// Multicycle unified instruction/data memory responder for the NITC-RISC24 core.
// Accepts one request in IDLE, inserts WAIT_CYCLES wait states, then pulses ready.
module mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;

  logic [31:0] mem [DEPTH];

  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wd;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  enter_resp;
  logic                  aligned;
  logic                  mem_wr;
  logic                  addr_hi_unused;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (req) state_nx = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt == 4'd1) state_nx = S_RESP;
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // With zero wait states the accepting edge is also the RESP-entry edge,
  // so the access must use the live inputs rather than the latched copies.
  always_comb begin
    acc_we   = we_q;
    acc_addr = addr_q;
    acc_wd   = wd_q;
    if (state == S_IDLE) begin
      acc_we   = we;
      acc_addr = addr;
      acc_wd   = wd;
    end
  end

  assign idx            = acc_addr[DEPTH_LOG2+1:2];
  assign addr_hi_unused = ^acc_addr[31:DEPTH_LOG2+2];
  assign aligned        = (acc_addr[1:0] == 2'b00);
  assign enter_resp     = (state_nx == S_RESP);
  assign mem_wr         = !reset && enter_resp && aligned && acc_we;

  always_ff @(posedge clk) begin
    if (mem_wr) mem[idx] <= acc_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      rd     <= '0;
      ready  <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= state_nx;
      ready <= (state_nx == S_RESP);
      busy  <= (state_nx != S_IDLE);
      if (state == S_IDLE && req) begin
        we_q   <= we;
        addr_q <= addr;
        wd_q   <= wd;
        cnt    <= 4'(WAIT_CYCLES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        err <= !aligned;
        if (aligned && !acc_we) rd <= mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (W=2, W=0, W=3)
// checked against a word-array reference model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req  [3];
  logic        we   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic [31:0] rd   [3];
  logic        ready[3];
  logic        err  [3];
  logic        busy [3];

  int wtab [3] = '{2, 0, 3};

  int vectors = 0;
  int fails   = 0;

  logic [31:0] mmem     [3][64];
  logic [31:0] model_rd [3];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]), .wd(wd[0]),
    .rd(rd[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0]));
  mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]), .wd(wd[1]),
    .rd(rd[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1]));
  mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(3)) u2 (
    .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .addr(addr[2]), .wd(wd[2]),
    .rd(rd[2]), .ready(ready[2]), .err(err[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with instance k idle.
  task automatic do_op(input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
    logic        exp_err;
    int          c;
    int          busy_cnt;
    int          ix;
    exp_err = (a[1:0] != 2'b00);
    ix = int'(a[7:2]);
    if (!exp_err) begin
      if (w) mmem[k][ix] = d;
      else   model_rd[k] = mmem[k][ix];
    end
    req[k] = 1'b1; we[k] = w; addr[k] = a; wd[k] = d;
    @(posedge clk); #1;
    req[k] = 1'b0;
    c = 0;
    busy_cnt = 0;
    while (ready[k] !== 1'b1 && c < 40) begin
      if (busy[k] === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      c++;
    end
    if (busy[k] === 1'b1) busy_cnt++;
    chk({tag, " latency"}, 32'(c), 32'(wtab[k]));
    chk({tag, " ready"}, 32'(ready[k]), 32'd1);
    chk({tag, " err"}, 32'(err[k]), 32'(exp_err));
    chk({tag, " rd"}, rd[k], model_rd[k]);
    chk({tag, " busy_len"}, 32'(busy_cnt), 32'(wtab[k] + 1));
    @(posedge clk); #1;
    chk({tag, " ready_drop"}, 32'(ready[k]), 32'd0);
    chk({tag, " busy_drop"}, 32'(busy[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) mmem[k][i] = '0;
      model_rd[k] = '0;
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wd[k] = '0;
    end

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset ready", 32'(ready[k]), 32'd0);
      chk("reset err",   32'(err[k]),   32'd0);
      chk("reset busy",  32'(busy[k]),  32'd0);
      chk("reset rd",    rd[k],         32'd0);
    end
    reset = 1'b0;

    // W=2 write-then-read
    do_op(0, 1'b1, 32'h10, 32'hDEADBEEF, "w2_write");
    do_op(0, 1'b0, 32'h10, 32'h0, "w2_read");
    // misaligned write leaves memory and rd untouched
    do_op(0, 1'b1, 32'h12, 32'hFFFFFFFF, "misaligned_write");
    do_op(0, 1'b0, 32'h10, 32'h0, "after_misaligned_read");
    // wrap-around
    do_op(0, 1'b1, 32'h100, 32'hA5A5A5A5, "wrap_write");
    do_op(0, 1'b0, 32'h000, 32'h0, "wrap_read");

    // W=0
    do_op(1, 1'b1, 32'h04, 32'h12345678, "w0_write");
    do_op(1, 1'b0, 32'h04, 32'h0, "w0_read");

    // req held high with W=3: one accept every 5 cycles
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0; wd[2] = '0;
    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      if (i == 21) req[2] = 1'b0;
      chk("busy_drop ready", 32'(ready[2]), 32'((i % 5) == 3));
    end
    chk("busy_drop idle", 32'(busy[2]), 32'd0);

    // reset during WAIT aborts a pending write
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h08; wd[0] = 32'h55;
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("midreset busy_before", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) model_rd[k] = '0;
    chk("midreset busy", 32'(busy[0]), 32'd0);
    chk("midreset rd", rd[0], 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("midreset ready", 32'(ready[0]), 32'd0);
      @(posedge clk); #1;
    end
    do_op(0, 1'b0, 32'h08, 32'h0, "midreset_read");

    // req coinciding with reset is not accepted
    req[1] = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    req[1] = 1'b0; reset = 1'b0;
    chk("req_with_reset busy", 32'(busy[1]), 32'd0);
    @(posedge clk); #1;
    chk("req_with_reset ready", 32'(ready[1]), 32'd0);
    for (int k = 0; k < 3; k++) model_rd[k] = '0;

    // randomized traffic against the reference model
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 30; n++) begin
        logic [31:0] a;
        a = $urandom & 32'h3FF;
        if (($urandom % 4) != 0) a[1:0] = 2'b00;
        do_op(k, 1'($urandom % 2), a, $urandom, "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
